// File: rtl/zigbee_cordic_sched_if.sv
// Requester/response handshake and CORDIC operand/phase bundle for zigbee_cordic_sched.
// Lane i occupies [i*IQ_SIZE +: IQ_SIZE] of req_I/req_Q and [i*W_SIZE +: W_SIZE] of rsp_W.
interface zigbee_cordic_sched_if #(
  parameter int IQ_SIZE = 5,
  parameter int W_SIZE  = 6,
  parameter int N_REQ   = 2
);
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*IQ_SIZE-1:0] req_I;
  logic [N_REQ*IQ_SIZE-1:0] req_Q;
  logic [N_REQ-1:0]         rsp_valid;
  logic [N_REQ*W_SIZE-1:0]  rsp_W;
  logic [N_REQ-1:0]         rsp_ready;
  logic [IQ_SIZE-1:0]       cordic_Ibb;
  logic [IQ_SIZE-1:0]       cordic_Qbb;
  logic [W_SIZE-1:0]        cordic_Wout;
  logic                     busy;

  modport master (
    output req_valid, req_I, req_Q, rsp_ready, cordic_Wout,
    input  req_ready, rsp_valid, rsp_W, cordic_Ibb, cordic_Qbb, busy
  );

  modport slave (
    input  req_valid, req_I, req_Q, rsp_ready, cordic_Wout,
    output req_ready, rsp_valid, rsp_W, cordic_Ibb, cordic_Qbb, busy
  );
endinterface

// File: rtl/zigbee_cordic_sched.sv
// Round-robin time-sharing of one CORDIC phase extractor between N_REQ requesters.
// A tag pipeline of CORDIC_LAT+1 stages routes each phase result back to its lane.
module zigbee_cordic_sched #(
  parameter int IQ_SIZE    = 5,
  parameter int W_SIZE     = 6,
  parameter int N_REQ      = 2,
  parameter int CORDIC_LAT = 0
) (
  input logic                  clk,
  input logic                  rst,
  zigbee_cordic_sched_if.slave bus
);
  localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DEPTH = CORDIC_LAT + 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);

  logic [PW-1:0]      ptr_r;
  logic [N_REQ-1:0]   pend_r;
  logic [N_REQ-1:0]   pend_nxt_s;
  logic [N_REQ-1:0]   elig_s;
  logic [N_REQ-1:0]   grant_s;
  logic [N_REQ-1:0]   consume_s;
  logic               grant_any_s;
  logic               take_s;
  logic [PW-1:0]      gidx_s;
  logic [PW-1:0]      idx_s;
  logic [N_REQ-1:0]   rsp_valid_r;
  logic [W_SIZE-1:0]  rsp_w_r [N_REQ];
  logic [IQ_SIZE-1:0] ibb_r;
  logic [IQ_SIZE-1:0] qbb_r;
  logic               busy_r;
  logic [DEPTH-1:0]   tag_v_r;
  logic [PW-1:0]      tag_id_r [DEPTH];

  // A lane whose response is consumed this cycle stays ineligible until its flag clears.
  assign consume_s  = rsp_valid_r & bus.rsp_ready;
  assign elig_s     = bus.req_valid & ~pend_r;
  assign pend_nxt_s = (pend_r & ~consume_s) | grant_s;

  // Round-robin search upward from ptr_r with wrap; no grant while reset is asserted.
  always_comb begin
    grant_any_s = 1'b0;
    gidx_s      = '0;
    idx_s       = ptr_r;
    take_s      = 1'b0;
    grant_s     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      take_s      = elig_s[idx_s] & ~grant_any_s & ~rst;
      gidx_s      = take_s ? idx_s : gidx_s;
      grant_any_s = grant_any_s | take_s;
      idx_s       = (idx_s == LAST_IDX) ? '0 : idx_s + PW'(1);
    end
    grant_s[gidx_s] = grant_any_s;
  end

  // Pointer, pending flags, busy and the CORDIC operand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r  <= '0;
      pend_r <= '0;
      busy_r <= 1'b0;
      ibb_r  <= '0;
      qbb_r  <= '0;
    end else begin
      pend_r <= pend_nxt_s;
      busy_r <= |pend_nxt_s;
      if (grant_any_s) begin
        ptr_r <= (gidx_s == LAST_IDX) ? '0 : gidx_s + PW'(1);
        ibb_r <= bus.req_I[gidx_s*IQ_SIZE +: IQ_SIZE];
        qbb_r <= bus.req_Q[gidx_s*IQ_SIZE +: IQ_SIZE];
      end
    end
  end

  // Tag pipeline: one stage per cycle of CORDIC latency plus the operand register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v_r <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        tag_id_r[k] <= '0;
      end
    end else begin
      tag_v_r[0]  <= grant_any_s;
      tag_id_r[0] <= gidx_s;
      for (int k = 1; k < DEPTH; k++) begin
        tag_v_r[k]  <= tag_v_r[k-1];
        tag_id_r[k] <= tag_id_r[k-1];
      end
    end
  end

  // Capture the phase into the tagged lane; pending ensures that lane is never still full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        rsp_w_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (tag_v_r[DEPTH-1] && (tag_id_r[DEPTH-1] == PW'(i))) begin
          rsp_valid_r[i] <= 1'b1;
          rsp_w_r[i]     <= bus.cordic_Wout;
        end else if (consume_s[i]) begin
          rsp_valid_r[i] <= 1'b0;
        end
      end
    end
  end

  // Pack the per-lane result registers onto the response bus.
  always_comb begin
    bus.rsp_W = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.rsp_W[i*W_SIZE +: W_SIZE] = rsp_w_r[i];
    end
  end

  assign bus.req_ready  = grant_s;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.cordic_Ibb = ibb_r;
  assign bus.cordic_Qbb = qbb_r;
  assign bus.busy       = busy_r;
endmodule

// File: tb/tb_zigbee_cordic_sched.sv
// Bench for zigbee_cordic_sched: a 2-lane combinational-CORDIC instance driven from a vector
// table, and a 4-lane 2-cycle-CORDIC instance checked against a queue-based reference model.
module tb_zigbee_cordic_sched;
  localparam int LAT_B = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  zigbee_cordic_sched_if #(.IQ_SIZE(5), .W_SIZE(6), .N_REQ(2)) ifa ();
  zigbee_cordic_sched_if #(.IQ_SIZE(5), .W_SIZE(6), .N_REQ(4)) ifb ();

  zigbee_cordic_sched #(.IQ_SIZE(5), .W_SIZE(6), .N_REQ(2), .CORDIC_LAT(0))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  zigbee_cordic_sched #(.IQ_SIZE(5), .W_SIZE(6), .N_REQ(4), .CORDIC_LAT(LAT_B))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // Ideal phase quantiser: atan2 in units of 5.625 deg, wrapped to 6-bit two's complement.
  function automatic logic [5:0] phase_of(input logic [4:0] i, input logic [4:0] q);
    real a;
    int  k;
    a = $atan2(real'(int'($signed(q))), real'(int'($signed(i)))) * 32.0 / 3.14159265358979;
    k = int'(a);
    return 6'(k);
  endfunction

  logic [5:0] pipe1, pipe2;
  assign ifa.cordic_Wout = phase_of(ifa.cordic_Ibb, ifa.cordic_Qbb);
  always @(posedge clk) begin
    pipe1 <= phase_of(ifb.cordic_Ibb, ifb.cordic_Qbb);
    pipe2 <= pipe1;
  end
  assign ifb.cordic_Wout = pipe2;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int v, i0, q0, i1, q1, rr;
    int rdy, rspv, w0, w1, busy;
  } vec_t;
  vec_t tbl[10];

  // Reference model for instance B: pending set, held results, in-flight ops with due edges.
  typedef struct { int lane; int w; int due; } op_t;
  op_t      flight[$];
  int       ptr_m, edge_m, ibb_m, qbb_m;
  bit [3:0] pend_m, rspv_m;
  int       w_m[4];
  int       gcnt[4];

  task automatic model_reset();
    ptr_m = 0; edge_m = 0; ibb_m = 0; qbb_m = 0;
    pend_m = '0; rspv_m = '0;
    for (int i = 0; i < 4; i++) w_m[i] = 0;
    flight.delete();
  endtask

  // One clock of instance B: check outputs, drive stimulus, check grant, advance the model.
  task automatic b_cycle(input int mode);
    int li[4];
    int lq[4];
    bit [3:0] v, rr, cons;
    int g, idx;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("b_rsp_valid", int'(ifb.rsp_valid[i]), int'(rspv_m[i]));
      chk("b_rsp_W", int'($signed(ifb.rsp_W[i*6 +: 6])), w_m[i]);
    end
    chk("b_busy", int'(ifb.busy), int'(|pend_m));
    chk("b_cordic_Ibb", int'($signed(ifb.cordic_Ibb)), ibb_m);
    chk("b_cordic_Qbb", int'($signed(ifb.cordic_Qbb)), qbb_m);
    for (int i = 0; i < 4; i++) begin
      li[i] = int'($urandom_range(0, 31)) - 16;
      lq[i] = int'($urandom_range(0, 31)) - 16;
      ifb.req_I[i*5 +: 5] = 5'(li[i]);
      ifb.req_Q[i*5 +: 5] = 5'(lq[i]);
    end
    case (mode)
      0: begin
        v = 4'($urandom);
        for (int i = 0; i < 4; i++) rr[i] = ($urandom_range(0, 3) != 0);
      end
      1: begin v = 4'b1111; rr = 4'b1111; end
      default: begin v = 4'b0000; rr = 4'b1111; end
    endcase
    ifb.req_valid = v;
    ifb.rsp_ready = rr;
    #1;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      idx = (ptr_m + k) % 4;
      if (g < 0 && v[idx] && !pend_m[idx]) g = idx;
    end
    chk("b_req_ready", int'(ifb.req_ready), (g < 0) ? 0 : (1 << g));
    for (int i = 0; i < 4; i++) if (ifb.req_ready[i]) gcnt[i]++;
    edge_m++;
    cons   = rspv_m & rr;
    pend_m = pend_m & ~cons;
    rspv_m = rspv_m & ~cons;
    for (int j = flight.size() - 1; j >= 0; j--) begin
      if (flight[j].due == edge_m) begin
        rspv_m[flight[j].lane] = 1'b1;
        w_m[flight[j].lane]    = flight[j].w;
        flight.delete(j);
      end
    end
    if (g >= 0) begin
      pend_m[g] = 1'b1;
      flight.push_back('{g, int'($signed(phase_of(5'(li[g]), 5'(lq[g])))), edge_m + LAT_B + 1});
      ptr_m = (g + 1) % 4;
      ibb_m = li[g];
      qbb_m = lq[g];
    end
  endtask

  initial begin
    int g0, g1;
    ifa.req_valid = '0; ifa.req_I = '0; ifa.req_Q = '0; ifa.rsp_ready = '0;
    ifb.req_valid = '0; ifb.req_I = '0; ifb.req_Q = '0; ifb.rsp_ready = '0;
    for (int i = 0; i < 4; i++) gcnt[i] = 0;
    model_reset();

    tbl[0] = '{1,  15,  0, 0,   0, 0,  1, 0,   0,   0, 1};
    tbl[1] = '{0,  15,  0, 0,   0, 0,  0, 1,   0,   0, 1};
    tbl[2] = '{0,   0,  0, 0,   0, 1,  0, 0,   0,   0, 0};
    tbl[3] = '{3,   0, 15, 0, -15, 3,  2, 0,   0,   0, 1};
    tbl[4] = '{3,   0, 15, 0, -15, 3,  1, 2,   0, -16, 1};
    tbl[5] = '{3,   0, 15, 0, -15, 3,  0, 1,  16, -16, 1};
    tbl[6] = '{3, -15,  0, 0, -15, 3,  2, 0,  16, -16, 1};
    tbl[7] = '{3, -15,  0, 0, -15, 3,  1, 2,  16, -16, 1};
    tbl[8] = '{3, -15,  0, 0, -15, 3,  0, 1, -32, -16, 1};
    tbl[9] = '{0,   0,  0, 0,   0, 3,  0, 0, -32, -16, 0};

    #2 rst = 1'b1;
    #2;
    chk("rst_a_req_ready", int'(ifa.req_ready), 0);
    chk("rst_a_rsp_valid", int'(ifa.rsp_valid), 0);
    chk("rst_a_rsp_W", int'(ifa.rsp_W), 0);
    chk("rst_a_cordic_Ibb", int'(ifa.cordic_Ibb), 0);
    chk("rst_a_cordic_Qbb", int'(ifa.cordic_Qbb), 0);
    chk("rst_a_busy", int'(ifa.busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < 10; r++) begin
      @(negedge clk);
      ifa.req_valid = 2'(tbl[r].v);
      ifa.rsp_ready = 2'(tbl[r].rr);
      ifa.req_I     = {5'(tbl[r].i1), 5'(tbl[r].i0)};
      ifa.req_Q     = {5'(tbl[r].q1), 5'(tbl[r].q0)};
      #1 chk($sformatf("a_row%0d_req_ready", r), int'(ifa.req_ready), tbl[r].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("a_row%0d_rsp_valid", r), int'(ifa.rsp_valid), tbl[r].rspv);
      chk($sformatf("a_row%0d_rsp_W0", r), int'($signed(ifa.rsp_W[5:0])), tbl[r].w0);
      chk($sformatf("a_row%0d_rsp_W1", r), int'($signed(ifa.rsp_W[11:6])), tbl[r].w1);
      chk($sformatf("a_row%0d_busy", r), int'(ifa.busy), tbl[r].busy);
    end

    // Backpressure on lane 1 while lane 0 keeps cycling.
    g0 = 0; g1 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        ifa.req_valid = 2'b11;
        ifa.rsp_ready = 2'b01;
        ifa.req_I     = {5'(-5), 5'(5)};
        ifa.req_Q     = {5'(-5), 5'(5)};
      end
      #1;
      g0 += int'(ifa.req_ready[0]);
      g1 += int'(ifa.req_ready[1]);
      if (c >= 2) begin
        chk("a_bp_rsp_valid1", int'(ifa.rsp_valid[1]), 1);
        chk("a_bp_rsp_W1_hold", int'($signed(ifa.rsp_W[11:6])), -24);
      end
    end
    chk("a_bp_lane1_grants", g1, 1);
    chk("a_bp_lane0_grants", g0, 3);
    @(negedge clk);
    ifa.req_valid = 2'b10;
    ifa.rsp_ready = 2'b11;
    #1 chk("a_bp_consume_cycle_ready", int'(ifa.req_ready), 0);
    @(negedge clk);
    #1 chk("a_bp_regrant_lane1", int'(ifa.req_ready), 2);
    @(negedge clk);
    ifa.req_valid = 2'b00;
    repeat (4) @(negedge clk);
    chk("a_bp_drained_busy", int'(ifa.busy), 0);

    repeat (300) b_cycle(0);
    for (int i = 0; i < 4; i++) gcnt[i] = 0;
    repeat (40) b_cycle(1);
    for (int i = 0; i < 4; i++) chk($sformatf("b_fair_lane%0d", i), int'(gcnt[i] >= 5), 1);

    // Reset with operations in flight.
    #3 rst = 1'b1;
    #1;
    chk("b_rst_rsp_valid", int'(ifb.rsp_valid), 0);
    chk("b_rst_rsp_W", int'(ifb.rsp_W), 0);
    chk("b_rst_cordic_Ibb", int'(ifb.cordic_Ibb), 0);
    chk("b_rst_cordic_Qbb", int'(ifb.cordic_Qbb), 0);
    chk("b_rst_busy", int'(ifb.busy), 0);
    chk("b_rst_req_ready", int'(ifb.req_ready), 0);
    @(negedge clk);
    ifb.req_valid = '0;
    rst = 1'b0;
    model_reset();
    repeat (5) b_cycle(2);
    repeat (12) b_cycle(1);
    repeat (150) b_cycle(0);
    repeat (8) b_cycle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
